// File: rtl/palette_lut_banked.sv
// palette_lut_banked: double-banked writable palette, 2-stage index->RGB pipeline, frame-stepped fade scaler
// Inputs:  i_clk, i_rst (async, active-high); pixel i_pix_index/i_pix_valid; i_frame_start, i_bank_sel;
//          write port i_wr_en/i_wr_bank/i_wr_addr/i_wr_data {R,G,B}; fade request i_fade_go/i_fade_dir.
// Outputs: o_red/o_green/o_blue/o_rgb_valid (2-cycle latency); o_fade_busy; o_fade_level (0..2^LVL_W).
module palette_lut_banked #(
  parameter int IDX_W     = 4,
  parameter int CH_W      = 4,
  parameter int LVL_W     = 4,
  parameter int FADE_STEP = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IDX_W-1:0]  i_pix_index,
  input  logic              i_pix_valid,
  input  logic              i_frame_start,
  input  logic              i_bank_sel,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [3*CH_W-1:0] i_wr_data,
  input  logic              i_fade_go,
  input  logic              i_fade_dir,
  output logic [CH_W-1:0]   o_red,
  output logic [CH_W-1:0]   o_green,
  output logic [CH_W-1:0]   o_blue,
  output logic              o_rgb_valid,
  output logic              o_fade_busy,
  output logic [LVL_W:0]    o_fade_level
);
  localparam int NE = 1 << IDX_W;
  localparam int PW = 3 * CH_W;
  localparam int FC_W = FADE_STEP > 1 ? $clog2(FADE_STEP) : 1;
  localparam logic [FC_W-1:0] FLAST = FC_W'(FADE_STEP - 1);
  localparam logic [FC_W-1:0] FONE = 1;
  localparam logic [LVL_W:0] LONE = 1;
  localparam logic [LVL_W:0] LMAX = {1'b1, {LVL_W{1'b0}}};
  localparam logic [11:0] DEF [16] = '{12'h660, 12'hFCC, 12'h8D0, 12'h000, 12'h050, 12'h520, 12'hFFF, 12'hAAA,
                                       12'hA4A, 12'h608, 12'h330, 12'h460, 12'h000, 12'h6A0, 12'h000, 12'h550};
  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
  logic [PW-1:0]    r_pal [2][NE];
  logic             r_bank;
  logic [PW-1:0]    r_s1_col;
  logic             r_s1_v;
  logic [CH_W-1:0]  r_red, r_green, r_blue;
  logic             r_rgb_valid;
  state_t           r_state, w_state;
  logic [FC_W-1:0]  r_fcnt, w_fcnt;
  logic [LVL_W:0]   r_level, w_level;
  logic             w_step;
  // The built-in table only applies to the 16-entry 4:4:4 configuration.
  function automatic logic [PW-1:0] def_entry(int i);
    logic [11:0] d;
    d = DEF[i[3:0]];
    return (IDX_W == 4 && CH_W == 4) ? PW'(d) : '0;
  endfunction
  // Product is formed at CH_W+LVL_W+1 bits so L = 2^LVL_W passes c through unchanged.
  function automatic logic [CH_W-1:0] scale(logic [CH_W-1:0] c, logic [LVL_W:0] l);
    logic [CH_W+LVL_W:0] p;
    p = {{(LVL_W+1){1'b0}}, c} * {{CH_W{1'b0}}, l};
    return CH_W'(p >> LVL_W);
  endfunction
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NE; i++)
          r_pal[b][i] <= def_entry(i);
    else if (i_wr_en)
      r_pal[i_wr_bank][i_wr_addr] <= i_wr_data;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)
      r_bank <= 1'b0;
    else if (i_frame_start)
      r_bank <= i_bank_sel;
  // Stage 1 reads with the pre-edge bank and contents, so same-cycle writes/swaps show up one lookup later.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_s1_col    <= '0;
      r_s1_v      <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_s1_col    <= r_pal[r_bank][i_pix_index];
      r_s1_v      <= i_pix_valid;
      r_red       <= r_s1_v ? scale(r_s1_col[3*CH_W-1 -: CH_W], r_level) : '0;
      r_green     <= r_s1_v ? scale(r_s1_col[2*CH_W-1 -: CH_W], r_level) : '0;
      r_blue      <= r_s1_v ? scale(r_s1_col[CH_W-1:0], r_level) : '0;
      r_rgb_valid <= r_s1_v;
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state <= IDLE;
      r_fcnt  <= '0;
      r_level <= LMAX;
    end else begin
      r_state <= w_state;
      r_fcnt  <= w_fcnt;
      r_level <= w_level;
    end
  // A frame_start arriving with fade_go in IDLE only starts the fade; counting begins next frame.
  always_comb begin
    w_state = r_state;
    w_fcnt  = r_fcnt;
    w_level = r_level;
    w_step  = 1'b0;
    if (r_state == IDLE) begin
      if (i_fade_go && !i_fade_dir && r_level != '0) begin
        w_state = FADE_OUT;
        w_fcnt  = '0;
      end else if (i_fade_go && i_fade_dir && r_level != LMAX) begin
        w_state = FADE_IN;
        w_fcnt  = '0;
      end
    end else if (i_frame_start) begin
      w_step  = r_fcnt == FLAST;
      w_fcnt  = w_step ? '0 : r_fcnt + FONE;
      w_level = !w_step ? r_level : r_state == FADE_OUT ? r_level - LONE : r_level + LONE;
      w_state = (w_step && (w_level == '0 || w_level == LMAX)) ? IDLE : r_state;
    end
  end
  assign o_red        = r_red;
  assign o_green      = r_green;
  assign o_blue       = r_blue;
  assign o_rgb_valid  = r_rgb_valid;
  assign o_fade_busy  = r_state != IDLE;
  assign o_fade_level = r_level;
endmodule

// File: tb/tb_palette_lut_banked.sv
// tb_palette_lut_banked: random + directed stimulus against a frame-counting reference model
module tb_palette_lut_banked;
  localparam int FS = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] pidx = '0, wa = '0;
  logic pv = 1'b0, fs = 1'b0, bsel = 1'b0, we = 1'b0, wb = 1'b0, go = 1'b0, dir = 1'b0;
  logic [11:0] wd = '0;
  logic [3:0] red, green, blue;
  logic rv, busy;
  logic [4:0] lvl;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  int got;
  int def [16] = '{'h660, 'hFCC, 'h8D0, 'h000, 'h050, 'h520, 'hFFF, 'hAAA,
                   'hA4A, 'h608, 'h330, 'h460, 'h000, 'h6A0, 'h000, 'h550};
  int strm [16];
  int m_pal [2][16];
  int m_bank, m_lvl, m_busy, m_dir, m_l0, m_nfr, m_s1c, m_s1v, m_rgb, m_rv;

  palette_lut_banked #(.IDX_W(4), .CH_W(4), .LVL_W(4), .FADE_STEP(FS)) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_index(pidx), .i_pix_valid(pv), .i_frame_start(fs),
    .i_bank_sel(bsel), .i_wr_en(we), .i_wr_bank(wb), .i_wr_addr(wa), .i_wr_data(wd),
    .i_fade_go(go), .i_fade_dir(dir), .o_red(red), .o_green(green), .o_blue(blue),
    .o_rgb_valid(rv), .o_fade_busy(busy), .o_fade_level(lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int scl(input int c, input int l);
    return (c * l) >> 4;
  endfunction

  // Reference: fade level derived from frames elapsed since the fade began.
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 16; i++)
          m_pal[b][i] = def[i];
      m_bank = 0; m_lvl = 16; m_busy = 0; m_dir = 0; m_l0 = 16; m_nfr = 0;
      m_s1c = 0; m_s1v = 0; m_rgb = 0; m_rv = 0;
    end else begin
      m_rv  = m_s1v;
      m_rgb = m_s1v ? (scl((m_s1c >> 8) & 15, m_lvl) << 8) | (scl((m_s1c >> 4) & 15, m_lvl) << 4)
                      | scl(m_s1c & 15, m_lvl) : 0;
      m_s1c = m_pal[m_bank][pidx];
      m_s1v = int'(pv);
      if (we) m_pal[wb][wa] = int'(wd);
      if (fs) m_bank = int'(bsel);
      if (m_busy != 0) begin
        if (fs) begin
          m_nfr++;
          m_lvl = m_dir != 0 ? m_l0 + m_nfr / FS : m_l0 - m_nfr / FS;
          if (m_lvl == (m_dir != 0 ? 16 : 0)) m_busy = 0;
        end
      end else if (go && (dir ? m_lvl < 16 : m_lvl > 0)) begin
        m_busy = 1; m_dir = int'(dir); m_l0 = m_lvl; m_nfr = 0;
      end
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("rgb", int'({red, green, blue}), m_rgb);
      chk("rgb_valid", int'(rv), m_rv);
      chk("fade_busy", int'(busy), m_busy);
      chk("fade_level", int'(lvl), m_lvl);
    end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, output int g);
    pidx = a; pv = 1'b1; tick();
    pv = 1'b0; tick();
    g = int'({rv, red, green, blue});
  endtask

  task automatic wr(input logic b, input logic [3:0] a, input logic [11:0] d);
    we = 1'b1; wb = b; wa = a; wd = d; tick();
    we = 1'b0;
  endtask

  task automatic frame();
    pidx = 4'($urandom); pv = 1'($urandom); fs = 1'b1; tick();
    fs = 1'b0; pv = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    #3 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) tick();
    chk("reset_level", int'(lvl), 16);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out", int'({rv, red, green, blue}), 0);
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      pidx = 4'(k); pv = k < 16; tick();
      if (k == 0) chk("valid_lag0", int'(rv), 0);
      if (k >= 1) strm[k-1] = int'({rv, red, green, blue});
    end
    pv = 1'b0;
    chk("stream_idx0", strm[0], 'h1660);
    chk("stream_idx1", strm[1], 'h1FCC);
    chk("stream_idx6", strm[6], 'h1FFF);
    chk("stream_idx15", strm[15], 'h1550);
    wr(1'b1, 4'd3, 12'hF00);
    bsel = 1'b1;
    rd(4'd3, got); chk("bank_before_swap", got, 'h1000);
    frame();
    rd(4'd3, got); chk("bank_after_swap", got, 'h1F00);
    we = 1'b1; wb = 1'b1; wa = 4'd3; wd = 12'h0F0; pidx = 4'd3; pv = 1'b1; tick();
    we = 1'b0; pv = 1'b0; tick();
    chk("collision_old", int'({rv, red, green, blue}), 'h1F00);
    rd(4'd3, got); chk("collision_new", got, 'h10F0);
    pidx = 4'd6; pv = 1'b0; tick(); tick();
    chk("invalid_black", int'({rv, red, green, blue}), 0);
    bsel = 1'b0; frame();
    go = 1'b1; dir = 1'b0; tick(); go = 1'b0;
    chk("fade_start_busy", int'(busy), 1);
    repeat (3) frame();
    chk("fade_lvl_3frames", int'(lvl), 16);
    frame();
    chk("fade_lvl_4frames", int'(lvl), 15);
    chk("model_lvl_4frames", m_lvl, 15);
    rd(4'd6, got); chk("idx6_at_15", got, 'h1EEE);
    go = 1'b1; dir = 1'b1; tick(); go = 1'b0;
    repeat (59) frame();
    chk("fade_lvl_63", int'(lvl), 1);
    chk("fade_busy_63", int'(busy), 1);
    frame();
    chk("fade_lvl_64", int'(lvl), 0);
    chk("fade_done_busy", int'(busy), 0);
    rd(4'd6, got); chk("idx6_at_0", got, 'h1000);
    go = 1'b1; dir = 1'b0; tick(); go = 1'b0;
    chk("noop_fade_busy", int'(busy), 0);
    go = 1'b1; dir = 1'b1; fs = 1'b1; tick(); go = 1'b0; fs = 1'b0;
    chk("fadein_busy", int'(busy), 1);
    chk("fadein_lvl0", int'(lvl), 0);
    repeat (63) frame();
    chk("fadein_lvl_63", int'(lvl), 15);
    chk("fadein_busy_63", int'(busy), 1);
    frame();
    chk("fadein_lvl_64", int'(lvl), 16);
    chk("fadein_done", int'(busy), 0);
    go = 1'b1; dir = 1'b0; tick(); go = 1'b0;
    repeat (5) frame();
    wr(1'b0, 4'd6, 12'h123);
    bsel = 1'b1; frame();
    #2 rst = 1'b1;
    #1 chk("midreset_lvl", int'(lvl), 16);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_out", int'({rv, red, green, blue}), 0);
    tick(); tick();
    rst = 1'b0;
    wr(1'b1, 4'd6, 12'hABC);
    rd(4'd6, got); chk("reset_restores", got, 'h1FFF);
    for (int c = 0; c < 3000; c++) begin
      pidx = 4'($urandom); pv = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 7) == 0; wb = 1'($urandom); wa = 4'($urandom); wd = 12'($urandom);
      fs = $urandom_range(0, 15) == 0; bsel = 1'($urandom);
      go = $urandom_range(0, 63) == 0; dir = 1'($urandom);
      tick();
    end
    pv = 1'b0; we = 1'b0; fs = 1'b0; go = 1'b0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
